alu_md: RTL and testbench
=========================

# alu_md

Parametrised execute-stage ALU for the MIPS core, successor to the single-cycle ALU. Keeps the existing 5-bit `alu_op` encoding for logic, add/sub, compare, shift and LUI, and adds:
- true signed-overflow detection;
- SLTU;
- an iterative multiply/divide engine with HI/LO registers;
- a valid/ready handshake;
- a flush input for exception squash.

It sits between ID/EX operand muxing and the EX/MEM register.

## Interface
- `WIDTH`, 32, datapath width (even, ≥8); shift amount uses `alu_a[$clog2(WIDTH)-1:0]`.
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `flush`  in  1  abort current mult/div; drop any accept this cycle.
- `in_valid`  in  1  operation presented.
- `in_ready`  out  1  unit can accept; equals (state==IDLE).
- `alu_op`  in  5  operation code.
- `alu_a`  in  WIDTH  operand a (rs / shift amount).
- `alu_b`  in  WIDTH  operand b (rt / immediate).
- `out_valid`  out  1  one-cycle pulse: `alu_res` valid.
- `alu_res`  out  WIDTH  registered result.
- `alu_int_ov`  out  1  signed overflow, qualified by `out_valid`.
- `md_busy`  out  1  mult/div in progress.
- `md_done`  out  1  one-cycle pulse: HI/LO just updated by mult/div.

## Operation
- Accept = `in_valid & in_ready & ~flush` at a rising edge.
- Single-cycle ops (registered, no state change):
  - AND 00000, OR 01000, NOR 10000, XOR 11000.
  - ADD 00001, SUB 01001 (wrapping). `alu_int_ov`=1 iff signed overflow; result is still written.
  - SLT 01010 (signed), SLTU 01011 (unsigned); result 0/1.
  - SRL 00100 = b>>sh; SRA 01100 = b>>>sh signed; SLL 10100 = b<<sh. sh = low log2(WIDTH) bits of a.
  - LUI 11100 = {b[WIDTH/2-1:0], WIDTH/2 zeros}.
  - MFHI 01110 / MFLO 01111 return HI / LO.
  - Any other code: result 0, ov 0, `out_valid` still pulses.
- HI/LO writes, no `out_valid`:
  - MTHI 10110: HI←a. MTLO 10111: LO←a.
- Mult/div ops, no `out_valid`:
  - MULT 00010, MULTU 00011: {HI,LO} = a*b, 2·WIDTH-bit product.
  - DIV 00110, DIVU 00111: LO = quotient truncated toward zero; HI = remainder with sign of dividend.
- Signed mult/div:
  - Operate on magnitudes; fix signs in FIX.
  - Most-negative / -1 gives LO=100…0, HI=0.
- Divide by zero, signed and unsigned: LO = all ones, HI = a. No trap.
- FSM:
  - IDLE → PREP on mult/div accept: latch magnitudes and sign flags, clear counter.
  - PREP → ITER.
  - ITER: WIDTH cycles. Shift-add multiply, or restoring divide, one bit per cycle. Counter 0..WIDTH-1; leave at WIDTH-1.
  - ITER → FIX: sign correction, HI/LO written at the FIX edge.
  - FIX → IDLE.
- `flush` in PREP/ITER/FIX → IDLE at next edge; HI/LO unchanged; no `md_done`.
- `flush` in IDLE blocks the accept.
- Reset: state IDLE, HI=LO=0, `alu_res`=0, `alu_int_ov`=0, `out_valid`=0, `md_done`=0, `md_busy`=0.
- Reset mid-iteration discards the operation.

## Timing
- Single-cycle op accepted at edge k: `alu_res`, `alu_int_ov` and `out_valid`=1 visible after edge k, for one cycle.
- Back-to-back single-cycle ops every cycle.
- MTHI/MTLO accepted at edge k: new HI/LO readable by an MFHI/MFLO accepted at edge k+1.
- Mult/div accepted at edge k:
  - `in_ready`=0 and `md_busy`=1 from k to k+WIDTH+2.
  - HI/LO updated and `md_done`=1 after edge k+WIDTH+2 (34 cycles at WIDTH=32).
  - `in_ready`=1 in that same cycle.
- While `in_ready`=0 the producer holds `in_valid` and its operands; nothing is sampled.
- `out_valid` never asserts during mult/div.
- Outputs are driven only from registers; no combinational path from inputs to outputs.

## Structure
- Package `alu_pkg`: the `alu_op` localparams above, and the FSM state enum IDLE/PREP/ITER/FIX.
- Sub-module `md_iter` (WIDTH-parametrised): magnitude/sign prep, iteration registers, counter, FIX correction. Outputs hi/lo/done.
- Top module: single-cycle datapath, HI/LO registers, handshake, flush.

## Test plan
All at WIDTH=32.
- ADD 0x7FFFFFFF+0x00000001 → `alu_res`=0x80000000, `alu_int_ov`=1. SUB 0x80000000−1 → 0x7FFFFFFF, ov=1. ADD 5+(−3) → 2, ov=0.
- SLT a=1, b=0xFFFFFFFF → 0. SLTU same operands → 1. SRA a=4, b=0xF0000000 → 0xFF000000. SRL same → 0x0F000000. LUI b=0x1234 → 0x12340000.
- MULT 0xFFFFFFFD×7 → after 34 cycles `md_done`=1, HI=0xFFFFFFFF, LO=0xFFFFFFEB. MULTU 0xFFFFFFFF×2 → HI=1, LO=0xFFFFFFFE. Then MFLO → `out_valid` next cycle with 0xFFFFFFEB.
- DIV −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000/−1 → LO=0x80000000, HI=0. DIVU 9/0 → LO=0xFFFFFFFF, HI=9.
- MTHI 0xAAAA, then DIV with `flush` at iteration 10 → `in_ready`=1 next cycle, HI still 0xAAAA, no `md_done`. `reset` low mid-MULT → all outputs 0, HI=LO=0.
- ADD with `in_valid` held during a busy DIV → no `out_valid` until the cycle after `md_done`; ADD accepted then, result pulses one cycle later.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - alu_op encodings and mult/div FSM state type
package alu_pkg;

    localparam logic [4:0] OP_AND   = 5'b00000;
    localparam logic [4:0] OP_OR    = 5'b01000;
    localparam logic [4:0] OP_NOR   = 5'b10000;
    localparam logic [4:0] OP_XOR   = 5'b11000;
    localparam logic [4:0] OP_ADD   = 5'b00001;
    localparam logic [4:0] OP_SUB   = 5'b01001;
    localparam logic [4:0] OP_SLT   = 5'b01010;
    localparam logic [4:0] OP_SLTU  = 5'b01011;
    localparam logic [4:0] OP_SRL   = 5'b00100;
    localparam logic [4:0] OP_SRA   = 5'b01100;
    localparam logic [4:0] OP_SLL   = 5'b10100;
    localparam logic [4:0] OP_LUI   = 5'b11100;
    localparam logic [4:0] OP_MFHI  = 5'b01110;
    localparam logic [4:0] OP_MFLO  = 5'b01111;
    localparam logic [4:0] OP_MTHI  = 5'b10110;
    localparam logic [4:0] OP_MTLO  = 5'b10111;
    localparam logic [4:0] OP_MULT  = 5'b00010;
    localparam logic [4:0] OP_MULTU = 5'b00011;
    localparam logic [4:0] OP_DIV   = 5'b00110;
    localparam logic [4:0] OP_DIVU  = 5'b00111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        ITER = 2'd2,
        FIX  = 2'd3
    } md_state_t;

endpackage

// File: rtl/md_iter.sv
// rtl/md_iter.sv - iterative shift-add multiply / restoring divide engine
module md_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             start,
    input  logic             op_signed,
    input  logic             op_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             done,
    output logic             idle
);

    localparam int CW = $clog2(WIDTH);

    md_state_t        state, state_nx;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic             neg_q, neg_r, is_div, div_zero;

    // p holds {partial product high, multiplier} for multiply and
    // {partial remainder, dividend/quotient} for divide.
    logic [2*WIDTH-1:0] p;
    logic [2*WIDTH-1:0] p_mul, p_div, prod;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [WIDTH-1:0]   quo, rem;

    logic a_neg, b_neg;
    assign a_neg = op_signed & a[WIDTH-1];
    assign b_neg = op_signed & b[WIDTH-1];

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic; flush abandons any operation in flight
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start) state_nx = PREP;
            PREP: state_nx = flush ? IDLE : ITER;
            ITER: begin
                if (flush)                      state_nx = IDLE;
                else if (cnt == CW'(WIDTH - 1)) state_nx = FIX;
            end
            FIX:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // FSM outputs: done only when FIX completes without a flush
    always_comb begin
        idle = (state == IDLE);
        done = (state == FIX) && !flush;
    end

    // One multiply step: conditionally add multiplicand, shift right
    always_comb begin
        mul_sum = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, mag_b} : '0);
        p_mul   = {mul_sum, p[WIDTH-1:1]};
    end

    // One restoring-divide step; a set top bit of the difference means the trial failed
    always_comb begin
        div_shift = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
        div_diff  = div_shift - {1'b0, mag_b};
        if (div_diff[WIDTH])
            p_div = {div_shift[WIDTH-1:0], p[WIDTH-2:0], 1'b0};
        else
            p_div = {div_diff[WIDTH-1:0], p[WIDTH-2:0], 1'b1};
    end

    // Operand latch at accept, load in PREP, one bit per ITER cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mag_a    <= '0;
            mag_b    <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            is_div   <= 1'b0;
            div_zero <= 1'b0;
            cnt      <= '0;
            p        <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    mag_a    <= a_neg ? -a : a;
                    mag_b    <= b_neg ? -b : b;
                    neg_q    <= a_neg ^ b_neg;
                    neg_r    <= a_neg;
                    is_div   <= op_div;
                    div_zero <= (b == '0);
                    cnt      <= '0;
                end
                PREP: p <= {{WIDTH{1'b0}}, mag_a};
                ITER: begin
                    p   <= is_div ? p_div : p_mul;
                    cnt <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    // FIX sign correction; divide by zero leaves remainder = |a|, so re-signing yields a
    always_comb begin
        prod = neg_q ? -p : p;
        quo  = p[WIDTH-1:0];
        rem  = p[2*WIDTH-1:WIDTH];
        if (is_div) begin
            lo = div_zero ? '1 : (neg_q ? -quo : quo);
            hi = neg_r ? -rem : rem;
        end else begin
            lo = prod[WIDTH-1:0];
            hi = prod[2*WIDTH-1:WIDTH];
        end
    end

endmodule

// File: rtl/alu_md.sv
// rtl/alu_md.sv - execute-stage ALU with HI/LO and iterative mult/div
module alu_md
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       alu_op,
    input  logic [WIDTH-1:0] alu_a,
    input  logic [WIDTH-1:0] alu_b,
    output logic             out_valid,
    output logic [WIDTH-1:0] alu_res,
    output logic             alu_int_ov,
    output logic             md_busy,
    output logic             md_done
);

    localparam int SW = $clog2(WIDTH);

    logic             md_idle, md_fin;
    logic [WIDTH-1:0] md_hi, md_lo;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             accept, is_md, is_mt, is_single, op_signed, op_div;
    logic [SW-1:0]    sh;
    logic [WIDTH-1:0] add_res, sub_res, sra_res, res;
    logic             ov;

    assign in_ready = md_idle;
    assign md_busy  = !md_idle;
    assign accept   = in_valid && md_idle && !flush;

    assign is_md     = (alu_op == OP_MULT) || (alu_op == OP_MULTU) ||
                       (alu_op == OP_DIV)  || (alu_op == OP_DIVU);
    assign is_mt     = (alu_op == OP_MTHI) || (alu_op == OP_MTLO);
    assign is_single = !is_md && !is_mt;
    assign op_signed = (alu_op == OP_MULT) || (alu_op == OP_DIV);
    assign op_div    = (alu_op == OP_DIV)  || (alu_op == OP_DIVU);

    assign sh      = alu_a[SW-1:0];
    assign add_res = alu_a + alu_b;
    assign sub_res = alu_a - alu_b;
    assign sra_res = $signed(alu_b) >>> sh;

    md_iter #(.WIDTH(WIDTH)) u_md_iter (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .start     (accept && is_md),
        .op_signed (op_signed),
        .op_div    (op_div),
        .a         (alu_a),
        .b         (alu_b),
        .hi        (md_hi),
        .lo        (md_lo),
        .done      (md_fin),
        .idle      (md_idle)
    );

    // Single-cycle result and overflow selection
    always_comb begin
        res = '0;
        ov  = 1'b0;
        case (alu_op)
            OP_AND:  res = alu_a & alu_b;
            OP_OR:   res = alu_a | alu_b;
            OP_NOR:  res = ~(alu_a | alu_b);
            OP_XOR:  res = alu_a ^ alu_b;
            OP_ADD: begin
                res = add_res;
                ov  = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) && (add_res[WIDTH-1] != alu_a[WIDTH-1]);
            end
            OP_SUB: begin
                res = sub_res;
                ov  = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) && (sub_res[WIDTH-1] != alu_a[WIDTH-1]);
            end
            OP_SLT:  res = {{(WIDTH-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
            OP_SLTU: res = {{(WIDTH-1){1'b0}}, (alu_a < alu_b)};
            OP_SRL:  res = alu_b >> sh;
            OP_SRA:  res = sra_res;
            OP_SLL:  res = alu_b << sh;
            OP_LUI:  res = {alu_b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            OP_MFHI: res = hi_q;
            OP_MFLO: res = lo_q;
            default: ;
        endcase
    end

    // HI/LO: engine result at FIX, otherwise MTHI/MTLO writes (never both in one cycle)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (md_fin) begin
            hi_q <= md_hi;
            lo_q <= md_lo;
        end else if (accept) begin
            if (alu_op == OP_MTHI) hi_q <= alu_a;
            if (alu_op == OP_MTLO) lo_q <= alu_a;
        end
    end

    // Registered outputs; result and overflow hold until the next single-cycle accept
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid  <= 1'b0;
            md_done    <= 1'b0;
            alu_res    <= '0;
            alu_int_ov <= 1'b0;
        end else begin
            out_valid <= accept && is_single;
            md_done   <= md_fin;
            if (accept && is_single) begin
                alu_res    <= res;
                alu_int_ov <= ov;
            end
        end
    end

endmodule

// File: tb/tb_alu_md.sv
// tb/tb_alu_md.sv - directed self-checking bench for alu_md
module tb_alu_md;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  alu_op = 5'd0;
    logic [31:0] alu_a = '0;
    logic [31:0] alu_b = '0;
    logic        out_valid;
    logic [31:0] alu_res;
    logic        alu_int_ov;
    logic        md_busy;
    logic        md_done;

    int checks = 0;
    int errors = 0;

    alu_md #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .out_valid  (out_valid),
        .alu_res    (alu_res),
        .alu_int_ov (alu_int_ov),
        .md_busy    (md_busy),
        .md_done    (md_done)
    );

    always #5 clk = ~clk;

    // Present one op for exactly one rising edge; returns 1ns after that edge
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        in_valid = 1'b1;
        alu_op   = op;
        alu_a    = a;
        alu_b    = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic read_reg(input logic [4:0] op, output logic [31:0] val, output logic vld);
        issue(op, 32'd0, 32'd0);
        val = alu_res;
        vld = out_valid;
    endtask

    // Start a mult/div and wait (bounded) for md_done; lat=0 means it never came
    task automatic run_md(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic rdy0, output logic busy0, output logic ovs);
        issue(op, a, b);
        rdy0 = in_ready;
        busy0 = md_busy;
        ovs = 1'b0;
        lat = 0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) ovs = 1'b1;
            if (md_done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        checks++; if (in_ready !== 1'b1)   begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0)  begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (alu_res !== 32'h0)   begin errors++; $display("FAIL reset_alu_res got=%h exp=0", alu_res); end
        checks++; if (alu_int_ov !== 1'b0) begin errors++; $display("FAIL reset_ov got=%b exp=0", alu_int_ov); end
        checks++; if (md_busy !== 1'b0)    begin errors++; $display("FAIL reset_md_busy got=%b exp=0", md_busy); end
        checks++; if (md_done !== 1'b0)    begin errors++; $display("FAIL reset_md_done got=%b exp=0", md_done); end
    endtask

    task automatic test_single_cycle();
        logic [4:0]  ops [12] = '{OP_ADD, OP_SUB, OP_ADD, OP_SLT, OP_SLTU, OP_SRA,
                                  OP_SRL, OP_LUI, OP_SLL, OP_NOR, OP_XOR, 5'b11111};
        logic [31:0] va  [12] = '{32'h7FFFFFFF, 32'h80000000, 32'd5, 32'd1, 32'd1, 32'd4,
                                  32'd4, 32'd0, 32'd8, 32'd0, 32'hF0F0F0F0, 32'h12345678};
        logic [31:0] vb  [12] = '{32'h00000001, 32'h00000001, 32'hFFFFFFFD, 32'hFFFFFFFF,
                                  32'hFFFFFFFF, 32'hF0000000, 32'hF0000000, 32'h00001234,
                                  32'h00ABCDEF, 32'h0, 32'hFF00FF00, 32'h9ABCDEF0};
        logic [31:0] er  [12] = '{32'h80000000, 32'h7FFFFFFF, 32'd2, 32'd0, 32'd1, 32'hFF000000,
                                  32'h0F000000, 32'h12340000, 32'hABCDEF00, 32'hFFFFFFFF,
                                  32'h0FF00FF0, 32'h0};
        logic        eo  [12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                                  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 12; i++) begin
            issue(ops[i], va[i], vb[i]);
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL op%0d_valid got=%b exp=1", i, out_valid); end
            checks++; if (alu_res !== er[i])  begin errors++; $display("FAIL op%0d_res got=%h exp=%h", i, alu_res, er[i]); end
            checks++; if (alu_int_ov !== eo[i]) begin errors++; $display("FAIL op%0d_ov got=%b exp=%b", i, alu_int_ov, eo[i]); end
        end
    endtask

    task automatic test_back_to_back();
        issue(OP_ADD, 32'd1, 32'd2);
        checks++; if (out_valid !== 1'b1 || alu_res !== 32'd3) begin errors++; $display("FAIL b2b_0 got=%b/%h exp=1/3", out_valid, alu_res); end
        issue(OP_OR, 32'h00F0, 32'h0F00);
        checks++; if (out_valid !== 1'b1 || alu_res !== 32'h0FF0) begin errors++; $display("FAIL b2b_1 got=%b/%h exp=1/0ff0", out_valid, alu_res); end
        issue(OP_AND, 32'hFF00, 32'h0FF0);
        checks++; if (out_valid !== 1'b1 || alu_res !== 32'h0F00) begin errors++; $display("FAIL b2b_2 got=%b/%h exp=1/0f00", out_valid, alu_res); end
        @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_pulse got=%b exp=0", out_valid); end
    endtask

    task automatic test_mult();
        int lat;
        logic rdy0, busy0, ovs, vld;
        logic [31:0] v;
        run_md(OP_MULT, 32'hFFFFFFFD, 32'd7, lat, rdy0, busy0, ovs);
        checks++; if (lat !== 34)      begin errors++; $display("FAIL mult_latency got=%0d exp=34", lat); end
        checks++; if (rdy0 !== 1'b0)   begin errors++; $display("FAIL mult_ready_busy got=%b exp=0", rdy0); end
        checks++; if (busy0 !== 1'b1)  begin errors++; $display("FAIL mult_md_busy got=%b exp=1", busy0); end
        checks++; if (ovs !== 1'b0)    begin errors++; $display("FAIL mult_out_valid_seen got=%b exp=0", ovs); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mult_ready_at_done got=%b exp=1", in_ready); end
        read_reg(OP_MFLO, v, vld);
        checks++; if (vld !== 1'b1 || v !== 32'hFFFFFFEB) begin errors++; $display("FAIL mult_lo got=%b/%h exp=1/ffffffeb", vld, v); end
        read_reg(OP_MFHI, v, vld);
        checks++; if (v !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi got=%h exp=ffffffff", v); end
        run_md(OP_MULTU, 32'hFFFFFFFF, 32'd2, lat, rdy0, busy0, ovs);
        checks++; if (lat !== 34) begin errors++; $display("FAIL multu_latency got=%0d exp=34", lat); end
        read_reg(OP_MFHI, v, vld);
        checks++; if (v !== 32'd1) begin errors++; $display("FAIL multu_hi got=%h exp=1", v); end
        read_reg(OP_MFLO, v, vld);
        checks++; if (v !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_lo got=%h exp=fffffffe", v); end
    endtask

    task automatic test_div();
        logic [4:0]  ops [4] = '{OP_DIV, OP_DIV, OP_DIVU, OP_DIV};
        logic [31:0] va  [4] = '{32'hFFFFFFF9, 32'h80000000, 32'd9, 32'hFFFFFFFB};
        logic [31:0] vb  [4] = '{32'd2, 32'hFFFFFFFF, 32'd0, 32'd0};
        logic [31:0] elo [4] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] ehi [4] = '{32'hFFFFFFFF, 32'h0, 32'd9, 32'hFFFFFFFB};
        int lat;
        logic rdy0, busy0, ovs, vld;
        logic [31:0] v;
        for (int i = 0; i < 4; i++) begin
            run_md(ops[i], va[i], vb[i], lat, rdy0, busy0, ovs);
            checks++; if (lat !== 34) begin errors++; $display("FAIL div%0d_latency got=%0d exp=34", i, lat); end
            @(posedge clk);
            #1;
            checks++; if (md_done !== 1'b0) begin errors++; $display("FAIL div%0d_done_pulse got=%b exp=0", i, md_done); end
            read_reg(OP_MFLO, v, vld);
            checks++; if (v !== elo[i]) begin errors++; $display("FAIL div%0d_lo got=%h exp=%h", i, v, elo[i]); end
            read_reg(OP_MFHI, v, vld);
            checks++; if (v !== ehi[i]) begin errors++; $display("FAIL div%0d_hi got=%h exp=%h", i, v, ehi[i]); end
        end
    endtask

    task automatic test_flush();
        logic seen;
        logic vld;
        logic [31:0] v;
        issue(OP_MTHI, 32'h0000AAAA, 32'd0);
        issue(OP_MTLO, 32'h00005555, 32'd0);
        issue(OP_DIV, 32'd7, 32'd2);
        repeat (11) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got=%b exp=1", in_ready); end
        checks++; if (md_busy !== 1'b0)  begin errors++; $display("FAIL flush_busy got=%b exp=0", md_busy); end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (md_done) seen = 1'b1;
            @(posedge clk);
            #1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL flush_md_done got=%b exp=0", seen); end
        read_reg(OP_MFHI, v, vld);
        checks++; if (v !== 32'h0000AAAA) begin errors++; $display("FAIL flush_hi got=%h exp=0000aaaa", v); end
        read_reg(OP_MFLO, v, vld);
        checks++; if (v !== 32'h00005555) begin errors++; $display("FAIL flush_lo got=%h exp=00005555", v); end
        @(negedge clk);
        flush = 1'b1;
        in_valid = 1'b1;
        alu_op = OP_ADD;
        alu_a = 32'd1;
        alu_b = 32'd1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_idle_block got=%b exp=0", out_valid); end
    endtask

    task automatic test_reset_mid();
        logic vld;
        logic [31:0] v;
        issue(OP_MULTU, 32'hFFFFFFFF, 32'd2);
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (alu_res !== 32'h0 || out_valid !== 1'b0 || alu_int_ov !== 1'b0)
            begin errors++; $display("FAIL rst_mid_outputs got=%h/%b/%b exp=0/0/0", alu_res, out_valid, alu_int_ov); end
        checks++; if (md_busy !== 1'b0 || md_done !== 1'b0 || in_ready !== 1'b1)
            begin errors++; $display("FAIL rst_mid_ctrl got=%b/%b/%b exp=0/0/1", md_busy, md_done, in_ready); end
        @(negedge clk);
        reset = 1'b1;
        read_reg(OP_MFHI, v, vld);
        checks++; if (vld !== 1'b1 || v !== 32'h0) begin errors++; $display("FAIL rst_mid_hi got=%b/%h exp=1/0", vld, v); end
        read_reg(OP_MFLO, v, vld);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL rst_mid_lo got=%h exp=0", v); end
    endtask

    task automatic test_busy_hold();
        int lat;
        logic early;
        logic vld;
        logic [31:0] v;
        issue(OP_DIV, 32'd100, 32'd7);
        @(negedge clk);
        in_valid = 1'b1;
        alu_op = OP_ADD;
        alu_a = 32'd3;
        alu_b = 32'd4;
        lat = 0;
        early = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) early = 1'b1;
            if (md_done) begin
                lat = i;
                break;
            end
        end
        checks++; if (lat !== 34)     begin errors++; $display("FAIL hold_latency got=%0d exp=34", lat); end
        checks++; if (early !== 1'b0) begin errors++; $display("FAIL hold_early_valid got=%b exp=0", early); end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || alu_res !== 32'd7) begin errors++; $display("FAIL hold_add got=%b/%h exp=1/7", out_valid, alu_res); end
        @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_add_pulse got=%b exp=0", out_valid); end
        read_reg(OP_MFLO, v, vld);
        checks++; if (v !== 32'd14) begin errors++; $display("FAIL hold_lo got=%h exp=e", v); end
        read_reg(OP_MFHI, v, vld);
        checks++; if (v !== 32'd2) begin errors++; $display("FAIL hold_hi got=%h exp=2", v); end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        test_reset();
        test_single_cycle();
        test_back_to_back();
        test_mult();
        test_div();
        test_flush();
        test_reset_mid();
        test_busy_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
